bit_serial_subtractor: RTL and testbench

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

---
 rtl/bit_serial_subtractor_pkg.sv | 29 ++
 rtl/fullSubtractor.sv | 13 +
 rtl/bit_serial_subtractor.sv | 131 +++++++++++++
 tb/tb_bit_serial_subtractor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width, adder-family constants.
package bit_serial_subtractor_pkg;

  localparam int unsigned BSS_WIDTH_DEFAULT = 16;

  // FSM encoding kept as plain constants so legacy blocks can share it
  localparam int unsigned STATE_W = 2;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;

  // Adder-family constants: initial carry/borrow into the LSB stage
  localparam logic SUB_BORROW_INIT = 1'b0;

  // Result flags captured together at the end of an operation
  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
  } sub_flags_t;

  localparam sub_flags_t SUB_FLAGS_RESET = '{bout: 1'b0, ovf: 1'b0, zero: 1'b1};

  // Signed overflow of a - b from the operand and result sign bits
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/fullSubtractor.sv
// One-bit full subtractor cell, the subtracting twin of the full adder cell.
module fullSubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic bout,
  output logic diff
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial a - b: one bit per cycle, LSB first, with borrow/overflow/zero flags.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = BSS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  sub_flags_t         flags_q, flags_d;

  logic               stage_diff;
  logic               stage_bout;
  logic [WIDTH-1:0]   diff_shift;
  logic               accept;

  fullSubtractor u_stage (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .bout (stage_bout),
    .diff (stage_diff)
  );

  assign diff_shift = {stage_diff, diff_q[WIDTH-1:1]};
  assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state logic: start is honoured in IDLE and DONE, ignored in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:           if (cnt_q == CNT_LAST) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle, capture flags on the last bit
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    busy_d   = (state_d == ST_RUN);
    done_d   = (state_d == ST_DONE);

    if (accept) begin
      a_d      = a;
      b_d      = b;
      a_msb_d  = a[WIDTH-1];
      b_msb_d  = b[WIDTH-1];
      borrow_d = SUB_BORROW_INIT;
      cnt_d    = '0;
    end else if (state_q == ST_RUN) begin
      a_d      = {1'b0, a_q[WIDTH-1:1]};
      b_d      = {1'b0, b_q[WIDTH-1:1]};
      diff_d   = diff_shift;
      borrow_d = stage_bout;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        flags_d.bout = stage_bout;
        flags_d.ovf  = sub_ovf(a_msb_q, b_msb_q, stage_diff);
        flags_d.zero = (diff_shift == '0);
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= SUB_FLAGS_RESET;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = flags_q.bout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor: arithmetic reference model, decoupled monitor.
module tb_bit_serial_subtractor;

  localparam int unsigned W   = 16;
  localparam longint      MOD = longint'(1) << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
    int           due;
  } exp_t;

  exp_t q[$];
  exp_t hold;
  bit   hold_valid = 1'b0;
  bit   armed      = 1'b0;
  int   cyc        = 0;
  int   m_rem      = 0;
  int   accepts    = 0;
  int   total      = 0;
  int   bad        = 0;

  // Reference result from plain integer arithmetic
  function automatic exp_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint ux, uy, sx, sy, sd;
    ux     = longint'(x);
    uy     = longint'(y);
    e.diff = W'((ux - uy + MOD) % MOD);
    e.bout = (ux < uy);
    sx     = x[W-1] ? ux - MOD : ux;
    sy     = y[W-1] ? uy - MOD : uy;
    sd     = sx - sy;
    e.ovf  = (sd > (MOD / 2) - 1) || (sd < -(MOD / 2));
    e.zero = (e.diff == '0);
    e.due  = 0;
    return e;
  endfunction

  // Protocol model: an accepted start occupies WIDTH cycles, then a done cycle that can accept again
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_rem      = 0;
        hold       = '{diff: '0, bout: 1'b0, ovf: 1'b0, zero: 1'b1, due: 0};
        hold_valid = 1'b1;
        armed      = 1'b1;
      end else if (armed) begin
        if (m_rem == 0 && start) begin
          e     = ref_sub(a, b);
          e.due = cyc + W;
          q.push_back(e);
          m_rem      = W;
          hold_valid = 1'b0;
          accepts++;
        end else if (m_rem > 0) begin
          m_rem--;
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the scoreboard away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        total++;
        if (busy !== (m_rem != 0)) begin
          bad++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (m_rem != 0));
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          total++;
          if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse cyc=%0d got=%b exp=1", cyc, done);
          end
          total++;
          if ({diff, bout, ovf, zero} !== {e.diff, e.bout, e.ovf, e.zero}) begin
            bad++;
            $display("FAIL result cyc=%0d got diff=%h bout=%b ovf=%b zero=%b exp diff=%h bout=%b ovf=%b zero=%b",
                     cyc, diff, bout, ovf, zero, e.diff, e.bout, e.ovf, e.zero);
          end
          hold       = e;
          hold_valid = 1'b1;
        end else begin
          total++;
          if (done !== 1'b0) begin
            bad++;
            $display("FAIL spurious_done cyc=%0d got=%b exp=0", cyc, done);
          end
          if (hold_valid) begin
            total++;
            if ({diff, bout, ovf, zero} !== {hold.diff, hold.bout, hold.ovf, hold.zero}) begin
              bad++;
              $display("FAIL hold cyc=%0d got diff=%h bout=%b ovf=%b zero=%b exp diff=%h bout=%b ovf=%b zero=%b",
                       cyc, diff, bout, ovf, zero, hold.diff, hold.bout, hold.ovf, hold.zero);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let everything drain, scrambling operands meanwhile; an expired budget counts as a failure
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || m_rem != 0) && n < budget) begin
      tick();
      a = W'($urandom);
      b = W'($urandom);
      n++;
    end
    total++;
    if (q.size() != 0 || m_rem != 0) begin
      bad++;
      $display("FAIL timeout cyc=%0d pending=%0d exp=0", cyc, q.size());
    end
    tick();
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(4 * W);
  endtask

  // Second start pulse with other operands while RUN is in progress
  task automatic op_with_poke(input logic [W-1:0] x, input logic [W-1:0] y, input int at);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at) tick();
    a     = ~x;
    b     = y ^ 16'h5a5a;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(4 * W);
  endtask

  // start held high across DONE: the second operation is taken straight from DONE
  task automatic held_pair(input logic [W-1:0] x1, input logic [W-1:0] y1,
                           input logic [W-1:0] x2, input logic [W-1:0] y2);
    int acc0;
    int n = 0;
    acc0  = accepts;
    a     = x1;
    b     = y1;
    start = 1'b1;
    tick();
    a = x2;
    b = y2;
    while (accepts < acc0 + 2 && n < 4 * W) begin
      tick();
      n++;
    end
    start = 1'b0;
    wait_idle(4 * W);
  endtask

  task automatic reset_mid(input logic [W-1:0] x, input logic [W-1:0] y, input int at);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7fff;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    do_op(16'h0005, 16'h0003);
    do_op(16'h0003, 16'h0005);
    do_op(16'h8000, 16'h0001);
    do_op(16'h7fff, 16'hffff);
    do_op(16'h1234, 16'h1234);
    do_op(16'h0000, 16'hffff);
    do_op(16'hffff, 16'h0000);
    op_with_poke(16'h00c8, 16'h0037, 4);
    held_pair(16'h1000, 16'h2000, 16'h4321, 16'h1234);
    reset_mid(16'habcd, 16'h0123, 7);
    do_op(16'h0042, 16'h0041);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1: do_op(pick(), pick());
        2:    op_with_poke(pick(), pick(), int'($urandom_range(0, W - 2)));
        3:    held_pair(pick(), pick(), pick(), pick());
        default: begin
          reset_mid(pick(), pick(), int'($urandom_range(0, W - 1)));
          do_op(pick(), pick());
        end
      endcase
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
